// File: rtl/lib_arbiter_pkg.sv
// Shared constants and types for the pixel-array readout path.
// Holds default array geometry, the encoder FSM states and the address-event record.
package lib_arbiter_pkg;

    localparam int unsigned ROWS  = 8;
    localparam int unsigned COLS  = 8;
    localparam int unsigned TS_W  = 16;
    localparam int unsigned ROW_W = $clog2(ROWS);
    localparam int unsigned COL_W = $clog2(COLS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_ACK  = 2'd2
    } aer_state_e;

    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
        logic [TS_W-1:0]  ts;
    } aer_evt_t;

endpackage

// File: rtl/aer_row_event_encoder_lsb.sv
// Combinational lowest-set-bit encoder: index of the lowest set bit plus an any-set flag.
module lsb_onehot_encoder #(
    parameter  int unsigned N     = 8,
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic found;

    always_comb begin
        idx_o = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (vec_i[i] && !found) begin
                idx_o = IDX_W'(i);
                found = 1'b1;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/aer_row_event_encoder.sv
// Captures the granted row's column events and serializes them as (row, col, ts)
// address-events on a valid/ready port, then pulses a one-hot row acknowledge.
module aer_row_event_encoder #(
    parameter  int unsigned ROWS  = lib_arbiter_pkg::ROWS,
    parameter  int unsigned COLS  = lib_arbiter_pkg::COLS,
    parameter  int unsigned TS_W  = lib_arbiter_pkg::TS_W,
    localparam int unsigned ROW_W = $clog2(ROWS),
    localparam int unsigned COL_W = $clog2(COLS)
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic [ROWS-1:0]  row_gnt_i,
    input  logic [COLS-1:0]  col_evt_i,
    output logic [ROWS-1:0]  row_ack_o,
    output logic             evt_valid_o,
    input  logic             evt_ready_i,
    output logic [ROW_W-1:0] evt_row_o,
    output logic [COL_W-1:0] evt_col_o,
    output logic [TS_W-1:0]  evt_ts_o,
    output logic             busy_o,
    output logic             proto_err_o
);

    import lib_arbiter_pkg::*;

    aer_state_e       state_q, state_d;
    logic [TS_W-1:0]  ts_cnt_q, ts_cnt_d;
    logic [TS_W-1:0]  ts_q, ts_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COLS-1:0]  col_mask_q, col_mask_d;
    logic             evt_valid_q, evt_valid_d;
    logic [COL_W-1:0] evt_col_q, evt_col_d;
    logic [ROWS-1:0]  row_ack_q, row_ack_d;
    logic             busy_q, busy_d;
    logic             proto_err_q, proto_err_d;

    logic [ROW_W-1:0] gnt_idx;
    logic             gnt_any;
    logic [COL_W-1:0] next_col;
    logic             next_any;
    logic             hs;
    logic             gnt_multi;

    lsb_onehot_encoder #(.N(ROWS)) u_row_enc (
        .vec_i (row_gnt_i),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    // Outputs are registered, so the column encoder looks at the mask as it will
    // be after this edge; evt_col then names the lowest pending bit in step with the mask.
    lsb_onehot_encoder #(.N(COLS)) u_col_enc (
        .vec_i (col_mask_d),
        .idx_o (next_col),
        .any_o (next_any)
    );

    assign hs        = evt_valid_q & evt_ready_i;
    assign gnt_multi = |(row_gnt_i & (row_gnt_i - ROWS'(1)));

    always_comb begin
        col_mask_d = col_mask_q;
        unique case (state_q)
            ST_IDLE: if (gnt_any) col_mask_d = col_evt_i;
            ST_EMIT: if (hs) col_mask_d = col_mask_q & ~(COLS'(1) << evt_col_q);
            ST_ACK:  col_mask_d = '0;
            default: col_mask_d = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        ts_cnt_d    = ts_cnt_q + TS_W'(1);
        ts_d        = ts_q;
        row_d       = row_q;
        evt_valid_d = evt_valid_q;
        evt_col_d   = evt_col_q;
        row_ack_d   = '0;
        proto_err_d = proto_err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (gnt_any) begin
                    row_d       = gnt_idx;
                    ts_d        = ts_cnt_q;
                    proto_err_d = proto_err_q | gnt_multi;
                    if (next_any) begin
                        state_d     = ST_EMIT;
                        evt_valid_d = 1'b1;
                        evt_col_d   = next_col;
                    end else begin
                        state_d   = ST_ACK;
                        row_ack_d = ROWS'(1) << gnt_idx;
                    end
                end
            end
            ST_EMIT: begin
                if (hs) begin
                    if (next_any) begin
                        evt_col_d = next_col;
                    end else begin
                        state_d     = ST_ACK;
                        evt_valid_d = 1'b0;
                        row_ack_d   = ROWS'(1) << row_q;
                    end
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d     = ST_IDLE;
                evt_valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q     <= ST_IDLE;
            ts_cnt_q    <= '0;
            ts_q        <= '0;
            row_q       <= '0;
            col_mask_q  <= '0;
            evt_valid_q <= 1'b0;
            evt_col_q   <= '0;
            row_ack_q   <= '0;
            busy_q      <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ts_cnt_q    <= ts_cnt_d;
            ts_q        <= ts_d;
            row_q       <= row_d;
            col_mask_q  <= col_mask_d;
            evt_valid_q <= evt_valid_d;
            evt_col_q   <= evt_col_d;
            row_ack_q   <= row_ack_d;
            busy_q      <= busy_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign row_ack_o   = row_ack_q;
    assign evt_valid_o = evt_valid_q;
    assign evt_row_o   = row_q;
    assign evt_col_o   = evt_col_q;
    assign evt_ts_o    = ts_q;
    assign busy_o      = busy_q;
    assign proto_err_o = proto_err_q;

endmodule

// File: doc/aer_row_event_encoder.md
# aer_row_event_encoder

Sequential stage directly downstream of the row priority arbiter in the pixel-array readout path. It takes the one-hot row grant, captures the granted row's column event vector, and serializes each active column into an address-event (row, column, timestamp) on a valid/ready output. It then pulses a one-hot row acknowledge back to the pixel array so the row can clear its request.

## Interface
- ROWS, 8, number of pixel rows (width of grant/ack vectors)
- COLS, 8, number of pixel columns
- TS_W, 16, timestamp counter width
- ROW_W, $clog2(ROWS), row address width (derived)
- COL_W, $clog2(COLS), column address width (derived)

- clk_i  input  1  single clock; all logic on rising edge
- reset_n_i  input  1  reset, synchronous, active-low
- row_gnt_i  input  ROWS  one-hot row grant from the row arbiter
- col_evt_i  input  COLS  column event bits of the granted row, valid while grant is held
- row_ack_o  output  ROWS  one-hot, one-cycle acknowledge to the serviced row
- evt_valid_o  output  1  address-event valid
- evt_ready_i  input  1  downstream ready
- evt_row_o  output  ROW_W  event row address
- evt_col_o  output  COL_W  event column address
- evt_ts_o  output  TS_W  timestamp latched at row capture
- busy_o  output  1  high in any state other than IDLE
- proto_err_o  output  1  sticky: grant was seen with more than one bit set

## Operation
- Free-running ts counter: +1 every cycle, wraps 2^TS_W-1 -> 0.
- FSM states: IDLE, EMIT, ACK.
- IDLE: if |row_gnt_i, then:
  - latch row index; if multiple bits are set, latch the lowest index and set proto_err_o
  - latch col_evt_i into col_mask and ts into ts_q
  - go to EMIT if col_mask != 0, else go to ACK
- EMIT:
  - evt_valid_o=1; evt_col_o = lowest set bit of col_mask; evt_row_o = latched row; evt_ts_o = ts_q.
  - On evt_valid_o & evt_ready_i, clear that bit. If it was the last bit, go to ACK.
  - evt_* held stable while valid & !ready.
  - row_gnt_i and col_evt_i are ignored outside IDLE.
- ACK: row_ack_o = one-hot of latched row for exactly one cycle, then IDLE.
- Upstream must drop the row request by the edge that ends the ACK cycle. A grant present in the following IDLE cycle is treated as a new row.
- proto_err_o clears only on reset.

## Timing
- Reset values: row_ack_o=0, evt_valid_o=0, evt_row_o=0, evt_col_o=0, evt_ts_o=0, busy_o=0, proto_err_o=0, ts=0, col_mask=0, state=IDLE.
- All outputs are registered; no combinational input-to-output path.
- Grant sampled at edge N:
  - evt_valid_o is high from cycle N+1.
  - With evt_ready_i held at 1, a row with k events takes k EMIT cycles, then 1 ACK cycle.
  - The next grant is sampled no earlier than the cycle after ACK (k+2 cycles per row).
- Zero-event row: ACK in cycle N+1, IDLE in cycle N+2.
- Backpressure: evt_ready_i low stalls EMIT indefinitely. The ts counter keeps running; evt_ts_o does not change.
- Reset mid-row: state returns to IDLE at the next edge with reset_n_i low. No ack is issued, pending events are discarded, and evt_valid_o drops.
- Column order within a row: ascending index.

## Structure
- Shared package (lib_arbiter_pkg): ROWS, COLS, TS_W, derived ROW_W/COL_W, FSM state enum typedef, and an event struct typedef {row, col, ts}.
- One sub-module: lsb_onehot_encoder. It is combinational, parameterized by width N, and outputs the lowest set-bit index plus an any-set flag. It is used twice: row index from row_gnt_i, and column index from col_mask.

## Test plan
- Reset, then grant 8'b0000_0100 with col_evt_i=8'b1000_0001 and ready=1:
  - events (row 2, col 0) then (row 2, col 7), both with the same ts
  - row_ack_o=8'b0000_0100 for one cycle; busy_o low afterwards
- Grant row 5 with col_evt_i=0: no evt_valid_o; row_ack_o[5] pulses in the cycle after the grant.
- Grant row 1 with col_evt_i=8'hFF, ready toggling 1/0: 8 events, cols 0..7 in order. Outputs stable during stalls; ack follows only the 8th handshake.
- Multi-hot grant 8'b0011_0000: row 4 serviced; proto_err_o=1 and stays set until reset.
- Assert reset_n_i low mid-EMIT after 2 of 4 events: next cycle evt_valid_o=0, no row_ack_o pulse, state IDLE. The following grant is serviced normally.
- Preload ts near 2^TS_W-1 (or run 65536 cycles): counter wraps to 0. An event captured after the wrap carries ts=0.
